psum_mem_ctrl: RTL and testbench

PSUM_MEM_CTRL -- requirements
Module: psum_mem_ctrl

---
 rtl/psum_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_psum_mem_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_mem_ctrl.sv
// Partial-sum scratch memory: pipelined reads with write forwarding, out-of-range
// detection and a sequential zero-clear engine that sweeps every word once.
module psum_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int MEM_DELAY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] memctrl_wadd,
    input  logic                  memctrl_wren,
    input  logic [DATA_WIDTH-1:0] memctrl_idat,
    input  logic [ADDR_WIDTH-1:0] memctrl_radd,
    input  logic                  memctrl_rden,
    output logic [DATA_WIDTH-1:0] memctrl_odat,
    output logic                  memctrl_ovld,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_err_oor,
    output logic [ADDR_WIDTH-1:0] dbg_clear_addr
);

    localparam int                    IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One in-flight read. 'fix' marks data that must not be forwarded into
    // (out-of-range reads and reads sampled while clearing both return 0).
    typedef struct packed {
        logic                  vld;
        logic                  fix;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } rd_slot_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] clear_ptr;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    rd_slot_t              pipe_q [MEM_DELAY];
    rd_slot_t              pipe_d [MEM_DELAY];
    logic                  err_q;

    logic wr_oor;
    logic rd_oor;
    logic wr_ok;
    logic rd_fix;
    logic clear_go;
    logic clear_last;

    // Full-width compares: an address with any high bit set is out of range,
    // never an alias of a low word.
    assign wr_oor     = (memctrl_wadd >= DEPTH_A);
    assign rd_oor     = (memctrl_radd >= DEPTH_A);
    assign wr_ok      = memctrl_wren && !wr_oor && (state_q == IDLE);
    assign rd_fix     = rd_oor || (state_q == CLEAR);
    assign clear_go   = i_clear && (state_q == IDLE);
    assign clear_last = (state_q == CLEAR) && (clear_ptr == LAST_A);

    // ---------------- FSM ----------------
    // NOTE: state and other flops use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_go)   state_d = CLEAR;
            CLEAR:   if (clear_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q == CLEAR);
    end

    // The pointer parks on the last word when the sweep ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clear_ptr <= '0;
        end else if (clear_go) begin
            clear_ptr <= '0;
        end else if ((state_q == CLEAR) && !clear_last) begin
            clear_ptr <= clear_ptr + 1'b1;
        end
    end

    assign dbg_clear_addr = clear_ptr;

    // ---------------- storage ----------------
    // NOTE: the array has no reset; contents are undefined until a sweep completes,
    // which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clear_ptr[IDX_W-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[memctrl_wadd[IDX_W-1:0]] <= memctrl_idat;
        end
    end

    // ---------------- read pipeline ----------------
    always_comb begin
        pipe_d[0].vld  = memctrl_rden;
        pipe_d[0].fix  = rd_fix;
        pipe_d[0].addr = memctrl_radd;
        if (rd_fix) begin
            pipe_d[0].dat = '0;
        end else if (wr_ok && (memctrl_wadd == memctrl_radd)) begin
            pipe_d[0].dat = memctrl_idat;
        end else begin
            pipe_d[0].dat = mem[memctrl_radd[IDX_W-1:0]];
        end

        // Later stages pick up any write that lands on their address while in flight.
        for (int i = 1; i < MEM_DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
            if (wr_ok && pipe_q[i-1].vld && !pipe_q[i-1].fix &&
                (memctrl_wadd == pipe_q[i-1].addr)) begin
                pipe_d[i].dat = memctrl_idat;
            end
        end
    end

    // Payloads only load with a valid entry, so the last stage holds its data
    // between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DELAY; i++) pipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < MEM_DELAY; i++) begin
                if (pipe_d[i].vld) pipe_q[i] <= pipe_d[i];
                else               pipe_q[i].vld <= 1'b0;
            end
        end
    end

    assign memctrl_ovld = pipe_q[MEM_DELAY-1].vld;
    assign memctrl_odat = pipe_q[MEM_DELAY-1].dat;

    // ---------------- sticky error ----------------
    // Writes dropped during a sweep are expected and do not flag an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (clear_go) begin
            err_q <= 1'b0;
        end else if ((memctrl_rden && rd_oor) ||
                     (memctrl_wren && wr_oor && (state_q == IDLE))) begin
            err_q <= 1'b1;
        end
    end

    assign o_err_oor = err_q;

endmodule

// File: tb/tb_psum_mem_ctrl.sv
// Bench for psum_mem_ctrl: two instances (read latency 1 and 3, 16 words) share
// stimulus; a cycle-history model derives every expected response from the rules.
module tb_psum_mem_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int DLY_A = 1;
    localparam int DLY_B = 3;
    localparam int H     = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wadd = '0;
    logic          wren = 1'b0;
    logic [DW-1:0] idat = '0;
    logic [AW-1:0] radd = '0;
    logic          rden = 1'b0;
    logic          i_clear = 1'b0;

    logic [DW-1:0] odat_a, odat_b;
    logic          ovld_a, ovld_b, busy_a, busy_b, err_a, err_b;
    logic [AW-1:0] dbg_a, dbg_b;

    psum_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .MEM_DELAY(DLY_A)) dut_a (
        .clk(clk), .rst(rst),
        .memctrl_wadd(wadd), .memctrl_wren(wren), .memctrl_idat(idat),
        .memctrl_radd(radd), .memctrl_rden(rden),
        .memctrl_odat(odat_a), .memctrl_ovld(ovld_a),
        .i_clear(i_clear), .o_busy(busy_a), .o_err_oor(err_a), .dbg_clear_addr(dbg_a)
    );

    psum_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .MEM_DELAY(DLY_B)) dut_b (
        .clk(clk), .rst(rst),
        .memctrl_wadd(wadd), .memctrl_wren(wren), .memctrl_idat(idat),
        .memctrl_radd(radd), .memctrl_rden(rden),
        .memctrl_odat(odat_b), .memctrl_ovld(ovld_b),
        .i_clear(i_clear), .o_busy(busy_b), .o_err_oor(err_b), .dbg_clear_addr(dbg_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: architectural memory, clear sweep, sticky error, plus a
    // per-cycle history of requests and accepted writes.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy = 1'b0;
    bit            m_err  = 1'b0;
    int            m_ptr  = 0;
    int            cyc    = 0;
    int            epoch  = 0;
    bit            h_rd  [H];
    bit            h_fix [H];
    bit            h_wr  [H];
    logic [AW-1:0] h_radd [H];
    logic [AW-1:0] h_wadd [H];
    logic [DW-1:0] h_base [H];
    logic [DW-1:0] h_idat [H];
    logic [DW-1:0] last_dat [2];

    task automatic drive_idle();
        wren = 1'b0;
        rden = 1'b0;
        i_clear = 1'b0;
    endtask

    // One clock: record inputs in the model, advance it, then compare every
    // output of both instances on the falling edge.
    task automatic step();
        int k;
        bit wr_ok, rd_oor, wr_oor;
        k = cyc;
        if (k >= H - 1) begin
            $display("FAIL history_overflow cyc=%0d", k);
            $fatal(1);
        end
        rd_oor = (radd >= DEPTH);
        wr_oor = (wadd >= DEPTH);
        wr_ok  = wren && !wr_oor && !m_busy;
        h_rd[k]   = rden;
        h_radd[k] = radd;
        h_fix[k]  = rd_oor || m_busy;
        h_base[k] = rd_oor ? '0 : m_mem[radd[3:0]];
        h_wr[k]   = wr_ok;
        h_wadd[k] = wadd;
        h_idat[k] = idat;
        if (!m_busy && i_clear) m_err = 1'b0;
        else if ((rden && rd_oor) || (wren && wr_oor && !m_busy)) m_err = 1'b1;
        if (m_busy) begin
            m_mem[m_ptr] = '0;
            if (m_ptr == DEPTH - 1) m_busy = 1'b0;
            else m_ptr++;
        end else begin
            if (wr_ok) m_mem[wadd[3:0]] = idat;
            if (i_clear) begin
                m_busy = 1'b1;
                m_ptr = 0;
            end
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            int            req;
            bit            ev;
            logic          ov, bz, er;
            logic [DW-1:0] od;
            logic [AW-1:0] dg;
            req = k - ((d == 0) ? DLY_A : DLY_B) + 1;
            ev = (req >= epoch) && h_rd[req];
            if (ev) begin
                last_dat[d] = h_fix[req] ? '0 : h_base[req];
                if (!h_fix[req])
                    for (int c = req; c <= k; c++)
                        if (h_wr[c] && h_wadd[c] == h_radd[req]) last_dat[d] = h_idat[c];
            end
            ov = (d == 0) ? ovld_a : ovld_b;
            od = (d == 0) ? odat_a : odat_b;
            bz = (d == 0) ? busy_a : busy_b;
            er = (d == 0) ? err_a  : err_b;
            dg = (d == 0) ? dbg_a  : dbg_b;
            n_vec++;
            if (ov !== ev) begin
                n_bad++;
                $display("FAIL ovld dut%0d cyc=%0d got=%b want=%b", d, k, ov, ev);
            end
            n_vec++;
            if (od !== last_dat[d]) begin
                n_bad++;
                $display("FAIL odat dut%0d cyc=%0d got=%h want=%h", d, k, od, last_dat[d]);
            end
            n_vec++;
            if (bz !== m_busy || er !== m_err || dg !== AW'(m_ptr)) begin
                n_bad++;
                $display("FAIL status dut%0d cyc=%0d busy/err/dbg got=%b/%b/%0d want=%b/%b/%0d",
                         d, k, bz, er, dg, m_busy, m_err, m_ptr);
            end
        end
    endtask

    task automatic pulse_reset(input int hold);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({ovld_a, ovld_b, busy_a, busy_b, err_a, err_b} !== 6'b0 ||
            odat_a !== '0 || odat_b !== '0 || dbg_a !== '0 || dbg_b !== '0) begin
            n_bad++;
            $display("FAIL reset_values ovld=%b%b busy=%b%b err=%b%b odat=%h/%h dbg=%0d/%0d want all 0",
                     ovld_a, ovld_b, busy_a, busy_b, err_a, err_b, odat_a, odat_b, dbg_a, dbg_b);
        end
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_ptr  = 0;
        last_dat[0] = '0;
        last_dat[1] = '0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        epoch = cyc;
    endtask

    task automatic do_clear(output int busy_cycles);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy_a === 1'b1; i++) begin
            busy_cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        drive_idle();
        pulse_reset(2);
        repeat (2) step();
    endtask

    task automatic test_clear_write_read();
        int bc;
        do_clear(bc);
        n_vec++;
        if (bc !== DEPTH) begin
            n_bad++;
            $display("FAIL clear_length got=%0d want=%0d", bc, DEPTH);
        end
        wren = 1'b1; wadd = 5; idat = 32'h0403_0201;
        step();
        wren = 1'b0;
        rden = 1'b1; radd = 5;
        step();
        rden = 1'b0;
        n_vec++;
        if (ovld_a !== 1'b1 || odat_a !== 32'h0403_0201) begin
            n_bad++;
            $display("FAIL read_after_write ovld=%b odat=%h want 1/04030201", ovld_a, odat_a);
        end
        repeat (3) step();
    endtask

    task automatic test_forwarding();
        wren = 1'b1; wadd = 7; idat = 32'h11;
        step();
        wren = 1'b0;
        rden = 1'b1; radd = 7;
        step();
        rden = 1'b0;
        wren = 1'b1; wadd = 7; idat = 32'h99;
        step();
        wren = 1'b1; wadd = 7; idat = 32'h22;
        step();
        wren = 1'b0;
        n_vec++;
        if (ovld_b !== 1'b1 || odat_b !== 32'h22) begin
            n_bad++;
            $display("FAIL inflight_forward ovld=%b odat=%h want 1/00000022", ovld_b, odat_b);
        end
        rden = 1'b1; radd = 9; wren = 1'b1; wadd = 9; idat = 32'h55;
        step();
        drive_idle();
        n_vec++;
        if (ovld_a !== 1'b1 || odat_a !== 32'h55) begin
            n_bad++;
            $display("FAIL write_first ovld=%b odat=%h want 1/00000055", ovld_a, odat_a);
        end
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wd [16];
        int pulses;
        for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            wren = 1'b1; wadd = i; idat = wd[i];
            step();
        end
        wren = 1'b0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            rden = 1'b1; radd = i;
            step();
            if (ovld_b === 1'b1) pulses++;
            n_vec++;
            if (ovld_a !== 1'b1 || odat_a !== wd[i]) begin
                n_bad++;
                $display("FAIL b2b addr=%0d ovld=%b odat=%h want 1/%h", i, ovld_a, odat_a, wd[i]);
            end
        end
        rden = 1'b0;
        repeat (3) begin
            step();
            if (ovld_b === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses !== 16) begin
            n_bad++;
            $display("FAIL b2b_pulses got=%0d want=16", pulses);
        end
    endtask

    task automatic test_oor();
        int bc;
        wren = 1'b1; wadd = 0; idat = 32'hAAAA_0000;
        step();
        wadd = 16; idat = 32'hDEAD_BEEF;
        step();
        wren = 1'b0;
        n_vec++;
        if (err_a !== 1'b1 || err_b !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_write_flag err=%b%b want 11", err_a, err_b);
        end
        rden = 1'b1; radd = 0;
        step();
        n_vec++;
        if (odat_a !== 32'hAAAA_0000) begin
            n_bad++;
            $display("FAIL oor_write_dropped odat=%h want aaaa0000", odat_a);
        end
        radd = 20;
        step();
        n_vec++;
        if (ovld_a !== 1'b1 || odat_a !== '0) begin
            n_bad++;
            $display("FAIL oor_read ovld=%b odat=%h want 1/00000000", ovld_a, odat_a);
        end
        radd = 32'h8000_0003;
        step();
        rden = 1'b0;
        repeat (3) step();
        do_clear(bc);
        n_vec++;
        if (bc !== DEPTH || err_a !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_after_oor busy_cycles=%0d err=%b want %0d/0", bc, err_a, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rden = 1'b1; radd = i;
            step();
            n_vec++;
            if (odat_a !== '0) begin
                n_bad++;
                $display("FAIL cleared_word addr=%0d got=%h want 0", i, odat_a);
            end
        end
        rden = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            wadd = (r < 7) ? AW'($urandom_range(0, 15)) :
                   (r < 9) ? AW'($urandom_range(16, 40)) : AW'($urandom);
            wren = ($urandom_range(0, 1) == 1);
            idat = $urandom;
            r = $urandom_range(0, 9);
            radd = (r < 3) ? wadd :
                   (r < 9) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(16, 255));
            rden = ($urandom_range(0, 9) < 6);
            i_clear = ($urandom_range(0, 99) < 2);
            step();
        end
        drive_idle();
        repeat (4) step();
    endtask

    task automatic test_reset_mid_clear();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        for (int i = 0; i < 40 && dbg_a !== AW'(8); i++) begin
            rden = 1'b1; radd = i % 16;
            step();
        end
        n_vec++;
        if (dbg_a !== AW'(8) || busy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL reach_ptr8 dbg=%0d busy=%b want 8/1", dbg_a, busy_a);
        end
        rden = 1'b1;
        pulse_reset(2);
        rden = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (ovld_a !== 1'b0 || ovld_b !== 1'b0 || busy_a !== 1'b0 || dbg_a !== '0) begin
                n_bad++;
                $display("FAIL post_abort ovld=%b%b busy=%b dbg=%0d want 00/0/0",
                         ovld_a, ovld_b, busy_a, dbg_a);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        last_dat[0] = '0;
        last_dat[1] = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        test_reset();
        test_clear_write_read();
        test_forwarding();
        test_back_to_back();
        test_oor();
        test_random();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
